// File: rtl/servo_command_sequencer_pkg.sv
// Shared constants, parser state encoding and the per-frame slew step for the
// servo command sequencer.
package servo_command_sequencer_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hFF;
    localparam logic [7:0] AXIS_X    = 8'h00;
    localparam logic [7:0] AXIS_Y    = 8'h01;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_AXIS = 2'd1,
        ST_POS  = 2'd2,
        ST_CHK  = 2'd3
    } parse_state_t;

    // Both operands are 0..127, so the signed difference always fits in 8 bits.
    function automatic logic [6:0] slew_next(input logic [6:0] pos,
                                             input logic [6:0] target,
                                             input logic [6:0] step);
        logic signed [7:0] diff;
        logic signed [7:0] lim;
        diff = $signed({1'b0, target}) - $signed({1'b0, pos});
        lim  = $signed({1'b0, step});
        if (diff > lim) begin
            slew_next = pos + step;
        end else if (diff < -lim) begin
            slew_next = pos - step;
        end else begin
            slew_next = target;
        end
    endfunction

endpackage

// File: rtl/servo_command_sequencer_tick_gen.sv
// PWM tick and servo frame tick generator: pwm_tick every CLK_DIV clocks,
// frame_tick on every FRAME_TICKS-th pwm_tick (coincident with it).
module servo_command_sequencer_tick_gen #(
    parameter int CLK_DIV     = 390,
    parameter int FRAME_TICKS = 2560
) (
    input  logic clk,
    input  logic reset,
    output logic pwm_tick,
    output logic frame_tick
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int FW = $clog2(FRAME_TICKS + 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [FW-1:0] tick_cnt_q, tick_cnt_d;
    logic          pwm_tick_q, pwm_tick_d;
    logic          frame_tick_q, frame_tick_d;

    always_comb begin
        div_cnt_d    = div_cnt_q + 1'b1;
        tick_cnt_d   = tick_cnt_q;
        pwm_tick_d   = 1'b0;
        frame_tick_d = 1'b0;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d  = '0;
            pwm_tick_d = 1'b1;
            if (tick_cnt_q == FRAME_LAST) begin
                tick_cnt_d   = '0;
                frame_tick_d = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q    <= '0;
            tick_cnt_q   <= '0;
            pwm_tick_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            pwm_tick_q   <= pwm_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pwm_tick   = pwm_tick_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: rtl/servo_command_sequencer.sv
// Servo command sequencer: parses FF/axis/pos/chk packets from the UART byte
// stream, slews X/Y positions toward their targets once per frame, and falls
// back to centre when packets stop arriving.
module servo_command_sequencer
    import servo_command_sequencer_pkg::*;
#(
    parameter int CLK_DIV        = 390,
    parameter int FRAME_TICKS    = 2560,
    parameter int SLEW_STEP      = 4,
    parameter int TIMEOUT_FRAMES = 50,
    parameter int CENTER         = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       pwm_tick,
    output logic       frame_tick,
    output logic [6:0] pos_x,
    output logic [6:0] pos_y,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic       timeout
);

    localparam logic [6:0] STEP       = 7'(SLEW_STEP);
    localparam logic [6:0] CENTER_POS = 7'(CENTER);
    localparam logic [7:0] TMO_FRAMES = 8'(TIMEOUT_FRAMES);

    parse_state_t state_q, state_d;
    logic         axis_q, axis_d;
    logic [6:0]   pos_byte_q, pos_byte_d;
    logic         pkt_ok_q, pkt_ok_d;
    logic         pkt_err_q, pkt_err_d;
    logic [6:0]   target_x_q, target_x_d;
    logic [6:0]   target_y_q, target_y_d;
    logic [6:0]   pos_x_q, pos_x_d;
    logic [6:0]   pos_y_q, pos_y_d;
    logic [7:0]   wd_cnt_q, wd_cnt_d;
    logic         timeout_q, timeout_d;

    servo_command_sequencer_tick_gen #(
        .CLK_DIV     (CLK_DIV),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .pwm_tick   (pwm_tick),
        .frame_tick (frame_tick)
    );

    always_comb begin
        state_d    = state_q;
        axis_d     = axis_q;
        pos_byte_d = pos_byte_q;
        pkt_ok_d   = 1'b0;
        pkt_err_d  = 1'b0;
        if (rx_valid) begin
            // A sync byte anywhere mid-packet starts a fresh packet.
            if (state_q != ST_HUNT && rx_data == SYNC_BYTE) begin
                pkt_err_d = 1'b1;
                state_d   = ST_AXIS;
            end else begin
                case (state_q)
                    ST_HUNT: if (rx_data == SYNC_BYTE) state_d = ST_AXIS;
                    ST_AXIS: begin
                        if (rx_data == AXIS_X || rx_data == AXIS_Y) begin
                            axis_d  = rx_data[0];
                            state_d = ST_POS;
                        end else begin
                            pkt_err_d = 1'b1;
                            state_d   = ST_HUNT;
                        end
                    end
                    ST_POS: begin
                        if (!rx_data[7]) begin
                            pos_byte_d = rx_data[6:0];
                            state_d    = ST_CHK;
                        end else begin
                            pkt_err_d = 1'b1;
                            state_d   = ST_HUNT;
                        end
                    end
                    default: begin
                        if (rx_data == {1'b0, pos_byte_q ^ {6'b0, axis_q}}) begin
                            pkt_ok_d = 1'b1;
                        end else begin
                            pkt_err_d = 1'b1;
                        end
                        state_d = ST_HUNT;
                    end
                endcase
            end
        end
    end

    always_comb begin
        target_x_d = target_x_q;
        target_y_d = target_y_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        wd_cnt_d   = wd_cnt_q;
        timeout_d  = timeout_q;
        // Slew reads the registered targets, so a write on this edge applies next frame.
        if (frame_tick) begin
            pos_x_d = slew_next(pos_x_q, target_x_q, STEP);
            pos_y_d = slew_next(pos_y_q, target_y_q, STEP);
        end
        if (pkt_ok_d) begin
            wd_cnt_d  = '0;
            timeout_d = 1'b0;
            if (axis_q) target_y_d = pos_byte_q;
            else        target_x_d = pos_byte_q;
        end else if (frame_tick && wd_cnt_q != TMO_FRAMES) begin
            wd_cnt_d = wd_cnt_q + 8'd1;
            if (wd_cnt_q + 8'd1 == TMO_FRAMES) begin
                timeout_d  = 1'b1;
                target_x_d = CENTER_POS;
                target_y_d = CENTER_POS;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_HUNT;
            axis_q     <= 1'b0;
            pos_byte_q <= '0;
            pkt_ok_q   <= 1'b0;
            pkt_err_q  <= 1'b0;
            target_x_q <= CENTER_POS;
            target_y_q <= CENTER_POS;
            pos_x_q    <= CENTER_POS;
            pos_y_q    <= CENTER_POS;
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            axis_q     <= axis_d;
            pos_byte_q <= pos_byte_d;
            pkt_ok_q   <= pkt_ok_d;
            pkt_err_q  <= pkt_err_d;
            target_x_q <= target_x_d;
            target_y_q <= target_y_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            wd_cnt_q   <= wd_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign pkt_ok  = pkt_ok_q;
    assign pkt_err = pkt_err_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_servo_command_sequencer.sv
// Bench for servo_command_sequencer: directed and random byte streams checked
// against a packet/frame-level reference model through expected queues.
module tb_servo_command_sequencer;

    localparam int CLK_DIV        = 4;
    localparam int FRAME_TICKS    = 8;
    localparam int SLEW_STEP      = 4;
    localparam int TIMEOUT_FRAMES = 50;
    localparam int CENTER         = 64;
    localparam int FRAME_CLKS     = CLK_DIV * FRAME_TICKS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       pwm_tick, frame_tick, pkt_ok, pkt_err, timeout;
    logic [6:0] pos_x, pos_y;

    servo_command_sequencer #(
        .CLK_DIV        (CLK_DIV),
        .FRAME_TICKS    (FRAME_TICKS),
        .SLEW_STEP      (SLEW_STEP),
        .TIMEOUT_FRAMES (TIMEOUT_FRAMES),
        .CENTER         (CENTER)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .pwm_tick   (pwm_tick),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pkt_ok     (pkt_ok),
        .pkt_err    (pkt_err),
        .timeout    (timeout)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_pkt_q[$];   // 1 = pkt_ok expected, 0 = pkt_err expected
    logic [13:0] exp_pos_q[$];   // {pos_x, pos_y} after a frame
    logic [7:0]  pend[$];        // bytes of the packet being assembled
    int  m_tgt[2];
    int  m_pos[2];
    int  m_wd;
    bit  m_tmo;
    bit  pkt_landing = 1'b0;
    bit  saw_frame = 1'b0;
    int  cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level reference: returns 0 = nothing, 1 = accepted, 2 = rejected.
    function automatic int ref_byte(input logic [7:0] b, output int axis, output int pos);
        int k;
        axis = 0;
        pos  = 0;
        if (pend.size() == 0) begin
            if (b == 8'hFF) pend.push_back(b);
            return 0;
        end
        k = pend.size() - 1;
        if (b == 8'hFF) begin
            pend.delete();
            pend.push_back(b);
            return 2;
        end
        if (k == 0) begin
            if (b <= 8'h01) begin pend.push_back(b); return 0; end
            pend.delete();
            return 2;
        end
        if (k == 1) begin
            if (b <= 8'h7F) begin pend.push_back(b); return 0; end
            pend.delete();
            return 2;
        end
        axis = int'(pend[1]);
        pos  = int'(pend[2]);
        pend.delete();
        return (b == (8'(axis) ^ 8'(pos))) ? 1 : 2;
    endfunction

    function automatic int slew(input int p, input int t);
        int d;
        d = t - p;
        if (d > SLEW_STEP)  return p + SLEW_STEP;
        if (d < -SLEW_STEP) return p - SLEW_STEP;
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int r, ax, ps;
        r = ref_byte(b, ax, ps);
        if (r == 1) exp_pkt_q.push_back(8'd1);
        else if (r == 2) exp_pkt_q.push_back(8'd0);
        pkt_landing = (r == 1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid    = 1'b0;
        pkt_landing = 1'b0;
        if (r == 1) begin
            m_tgt[ax] = ps;
            m_wd      = 0;
            m_tmo     = 1'b0;
        end
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        send_byte(a); send_byte(b); send_byte(c); send_byte(d);
    endtask

    task automatic wait_frames(input int n);
        int seen, budget;
        seen   = 0;
        budget = (n + 1) * FRAME_CLKS + 4;
        while (seen < n && budget > 0) begin
            @(posedge clk); #1;
            budget--;
            if (frame_tick) seen++;
        end
        if (seen < n) check("wait_frames_budget", seen, n);
        idle(2);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        idle(3);
        m_tgt[0] = CENTER; m_tgt[1] = CENTER;
        m_pos[0] = CENTER; m_pos[1] = CENTER;
        m_wd  = 0;
        m_tmo = 1'b0;
        pend.delete();
        exp_pkt_q.delete();
        exp_pos_q.delete();
        check("reset_pos_x", pos_x, CENTER);
        check("reset_pos_y", pos_y, CENTER);
        check("reset_timeout", timeout, 0);
        check("reset_pulses", {pwm_tick, frame_tick, pkt_ok, pkt_err}, 0);
        reset = 1'b0;
    endtask

    // ---------------- tick timing checker ----------------
    always @(posedge clk or posedge reset) begin
        if (reset) cyc = 0;
        else       cyc++;
    end

    always @(negedge clk) begin : tick_chk
        bit exp_p, exp_f;
        if (!reset) begin
            exp_p = (cyc > 0) && (cyc % CLK_DIV == 0);
            exp_f = (cyc > 0) && (cyc % FRAME_CLKS == 0);
            if (exp_p || pwm_tick)   check("pwm_tick", pwm_tick, exp_p);
            if (exp_f || frame_tick) check("frame_tick", frame_tick, exp_f);
        end
    end

    // ---------------- frame-level reference model ----------------
    always @(negedge clk) begin
        if (!reset && frame_tick) begin
            check("timeout_at_frame", timeout, m_tmo);
            m_pos[0] = slew(m_pos[0], m_tgt[0]);
            m_pos[1] = slew(m_pos[1], m_tgt[1]);
            if (!pkt_landing && m_wd < TIMEOUT_FRAMES) begin
                m_wd++;
                if (m_wd == TIMEOUT_FRAMES) begin
                    m_tmo    = 1'b1;
                    m_tgt[0] = CENTER;
                    m_tgt[1] = CENTER;
                end
            end
            exp_pos_q.push_back({7'(m_pos[0]), 7'(m_pos[1])});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        logic [7:0]  e;
        logic [13:0] ep;
        if (reset) begin
            saw_frame = 1'b0;
        end else begin
            if (pkt_ok || pkt_err) begin
                if (exp_pkt_q.size() == 0) begin
                    check("unexpected_pkt_pulse", {pkt_ok, pkt_err}, 0);
                end else begin
                    e = exp_pkt_q.pop_front();
                    check("pkt_result", {pkt_ok, pkt_err}, (e == 8'd1) ? 2 : 1);
                end
            end
            if (saw_frame) begin
                if (exp_pos_q.size() == 0) begin
                    check("pos_queue_empty", 0, 1);
                end else begin
                    ep = exp_pos_q.pop_front();
                    check("pos_x", pos_x, ep[13:7]);
                    check("pos_y", pos_y, ep[6:0]);
                end
            end
            saw_frame = frame_tick;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int kind, ax, ps;
        do_reset();

        wait_frames(2);
        check("idle_pos_x", pos_x, CENTER);

        send4(8'hFF, 8'h00, 8'h70, 8'h70);
        wait_frames(14);
        check("x_reaches_112", pos_x, 112);
        check("y_holds_64", pos_y, 64);

        send4(8'hFF, 8'h01, 8'h10, 8'h11);
        send4(8'hFF, 8'h01, 8'h10, 8'h12);
        wait_frames(13);
        check("y_reaches_16", pos_y, 16);

        send_byte(8'hFF); send_byte(8'h00);
        send4(8'hFF, 8'h01, 8'h20, 8'h21);
        wait_frames(5);
        check("y_reaches_32", pos_y, 32);

        send4(8'hFF, 8'h00, 8'h64, 8'h64);
        wait_frames(TIMEOUT_FRAMES + 10);
        check("timeout_set", timeout, 1);
        check("x_back_center", pos_x, CENTER);
        check("y_back_center", pos_y, CENTER);
        send4(8'hFF, 8'h00, 8'h0A, 8'h0A);
        check("timeout_cleared", timeout, 0);
        wait_frames(15);
        check("x_reaches_10", pos_x, 10);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            ax   = $urandom_range(0, 1);
            ps   = $urandom_range(0, 127);
            case (kind)
                0, 1: send4(8'hFF, 8'(ax), 8'(ps), 8'(ax) ^ 8'(ps));
                2: send4(8'hFF, 8'(ax), 8'(ps), (8'(ax) ^ 8'(ps)) ^ 8'(1 << $urandom_range(0, 6)));
                3: send_byte(8'($urandom_range(0, 255)));
                default: send4(8'hFF, 8'(ax), 8'($urandom_range(128, 254)), 8'h00);
            endcase
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) wait_frames($urandom_range(1, 3));
        end
        wait_frames(2);

        send_byte(8'hFF);
        send_byte(8'h00);
        do_reset();
        send_byte(8'h50);
        send_byte(8'h00);
        wait_frames(2);
        check("post_reset_pos_x", pos_x, CENTER);
        send4(8'hFF, 8'h01, 8'h05, 8'h04);
        wait_frames(16);
        check("post_reset_y_reaches_5", pos_y, 5);

        idle(4);
        check("pkt_queue_drained", exp_pkt_q.size(), 0);
        check("pos_queue_drained", exp_pos_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
